// File: rtl/record_serializer.sv
// record_serializer: buffers 47-bit tagger records in a small FIFO and
// streams each one to the host as six bytes, MSB first, over valid/ack.
module record_serializer #(
    parameter int DEPTH_LOG2 = 4,
    parameter int LOST_W     = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [46:0]           rec_data,
    input  logic                  rec_ready,
    input  logic                  enable,
    output logic [7:0]            out_byte,
    output logic                  out_valid,
    input  logic                  out_ack,
    output logic [DEPTH_LOG2:0]   fifo_level,
    output logic [LOST_W-1:0]     lost_count,
    output logic                  overflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LVL = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic {
        S_IDLE,
        S_SEND
    } state_t;

    logic [47:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  pending_lost;

    state_t                state;
    state_t                state_nxt;
    logic [47:0]           shift;
    logic [2:0]            byte_idx;

    logic                  full;
    logic                  empty;
    logic                  wr_en;
    logic                  drop;
    logic                  pop;
    logic                  advance;
    logic                  last_byte;
    logic [47:0]           word;

    assign full      = (count == FULL_LVL);
    assign empty     = (count == '0);
    assign wr_en     = rec_ready && enable && !full;
    assign drop      = rec_ready && enable && full;
    assign last_byte = (byte_idx == 3'd5);

    // Bit 44 flags the first record stored after one or more drops.
    assign word = {1'b0, rec_data[46:45],
                   rec_data[44] | pending_lost,
                   rec_data[43:0]};

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= word;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_lost <= 1'b0;
            overflow     <= 1'b0;
            lost_count   <= '0;
        end else if (drop) begin
            pending_lost <= 1'b1;
            overflow     <= 1'b1;
            if (lost_count != '1) begin
                lost_count <= lost_count + 1'b1;
            end
        end else if (wr_en) begin
            pending_lost <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            shift    <= '0;
            byte_idx <= '0;
        end else begin
            state <= state_nxt;
            if (pop) begin
                shift    <= mem[rd_ptr];
                byte_idx <= '0;
            end else if (advance) begin
                shift    <= shift << 8;
                byte_idx <= byte_idx + 3'd1;
            end
        end
    end

    // A pop on the last ack chains records with no idle cycle between them.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        advance   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                if (out_ack) begin
                    if (!last_byte) begin
                        advance = 1'b1;
                    end else if (!empty) begin
                        pop = 1'b1;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign out_valid  = (state == S_SEND);
    assign out_byte   = out_valid ? shift[47:40] : 8'h00;
    assign fifo_level = count;

endmodule

// File: tb/tb_record_serializer.sv
// tb_record_serializer: directed scenarios plus random traffic, all
// checked against a queue-based reference model of the serializer.
module tb_record_serializer;

    localparam int DL = 4;
    localparam int LW = 16;
    localparam int DEPTH = 1 << DL;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [46:0]   rec_data = '0;
    logic          rec_ready = 1'b0;
    logic          enable = 1'b0;
    logic          out_ack = 1'b0;
    logic [7:0]    out_byte;
    logic          out_valid;
    logic [DL:0]   fifo_level;
    logic [LW-1:0] lost_count;
    logic          overflow;

    int total = 0;
    int bad = 0;

    logic [7:0] exp1 [6] = '{8'h20, 8'h30, 8'h00, 8'h00, 8'h00, 8'h10};
    logic [7:0] expm [6] = '{8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [46:0] rec1 = {1'b0, 1'b1, 5'b0, 4'h3, 36'h10};

    always #5 clk = ~clk;

    record_serializer #(.DEPTH_LOG2(DL), .LOST_W(LW)) dut (
        .clk        (clk),
        .reset      (reset),
        .rec_data   (rec_data),
        .rec_ready  (rec_ready),
        .enable     (enable),
        .out_byte   (out_byte),
        .out_valid  (out_valid),
        .out_ack    (out_ack),
        .fifo_level (fifo_level),
        .lost_count (lost_count),
        .overflow   (overflow)
    );

    // Reference model: queue of stored records plus the record being sent.
    logic [47:0]   m_q [$];
    logic [47:0]   m_cur;
    int            m_left;
    bit            m_pend;
    bit            m_ovf;
    logic [LW-1:0] m_lost;
    bit            m_full;
    bit            m_take;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_q.delete();
            m_cur  = '0;
            m_left = 0;
            m_pend = 0;
            m_ovf  = 0;
            m_lost = '0;
        end else begin
            m_full = (m_q.size() == DEPTH);
            m_take = 0;
            if (m_left == 0) begin
                m_take = (m_q.size() > 0);
            end else if (out_ack) begin
                if (m_left == 1) m_take = (m_q.size() > 0);
                m_left = m_left - 1;
            end
            if (m_take) begin
                m_cur  = m_q.pop_front();
                m_left = 6;
            end
            if (rec_ready && enable) begin
                if (!m_full) begin
                    m_q.push_back({1'b0, rec_data[46:45],
                                   rec_data[44] | m_pend, rec_data[43:0]});
                    m_pend = 0;
                end else begin
                    m_pend = 1;
                    m_ovf  = 1;
                    if (m_lost != '1) m_lost = m_lost + 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            total++;
            if (out_valid !== (m_left > 0)) begin
                bad++;
                $display("FAIL model_valid t=%0t got=%b want=%b",
                         $time, out_valid, m_left > 0);
            end
            if (m_left > 0) begin
                total++;
                if (out_byte !== m_cur[8*m_left-1 -: 8]) begin
                    bad++;
                    $display("FAIL model_byte t=%0t got=%h want=%h",
                             $time, out_byte, m_cur[8*m_left-1 -: 8]);
                end
            end
            total++;
            if (fifo_level !== (DL+1)'(m_q.size())) begin
                bad++;
                $display("FAIL model_level t=%0t got=%0d want=%0d",
                         $time, fifo_level, m_q.size());
            end
            total++;
            if (lost_count !== m_lost || overflow !== m_ovf) begin
                bad++;
                $display("FAIL model_lost t=%0t got=%0d/%b want=%0d/%b",
                         $time, lost_count, overflow, m_lost, m_ovf);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || out_byte !== 8'h00 || fifo_level !== '0 ||
            lost_count !== '0 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL reset got v=%b b=%h l=%0d lost=%0d o=%b want zeros",
                     out_valid, out_byte, fifo_level, lost_count, overflow);
        end
        reset = 1'b0;
    endtask

    task automatic test_single();
        enable  = 1'b1;
        out_ack = 1'b1;
        @(negedge clk);
        rec_data  = rec1;
        rec_ready = 1'b1;
        @(negedge clk);
        rec_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_early got v=%b want 0", out_valid);
        end
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            total++;
            if (out_valid !== 1'b1 || out_byte !== exp1[i]) begin
                bad++;
                $display("FAIL single_byte%0d got v=%b b=%h want 1/%h",
                         i, out_valid, out_byte, exp1[i]);
            end
            @(negedge clk);
        end
        total++;
        if (out_valid !== 1'b0 || fifo_level !== '0) begin
            bad++;
            $display("FAIL single_end got v=%b l=%0d want 0/0",
                     out_valid, fifo_level);
        end
    endtask

    task automatic test_backpressure();
        out_ack = 1'b0;
        @(negedge clk);
        rec_data  = rec1;
        rec_ready = 1'b1;
        @(negedge clk);
        rec_ready = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            total++;
            if (out_valid !== 1'b1 || out_byte !== 8'h20) begin
                bad++;
                $display("FAIL bp_hold%0d got v=%b b=%h want 1/20",
                         i, out_valid, out_byte);
            end
            @(negedge clk);
        end
        out_ack = 1'b1;
        for (int i = 0; i < 6; i++) begin
            total++;
            if (out_valid !== 1'b1 || out_byte !== exp1[i]) begin
                bad++;
                $display("FAIL bp_byte%0d got v=%b b=%h want 1/%h",
                         i, out_valid, out_byte, exp1[i]);
            end
            @(negedge clk);
        end
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_dup got v=%b want 0", out_valid);
        end
    endtask

    task automatic test_overflow();
        int n;
        out_ack = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            rec_data        = {$urandom, $urandom};
            rec_data[44:40] = 5'b0;
            rec_ready       = 1'b1;
            @(negedge clk);
        end
        rec_ready = 1'b0;
        // First record moves into the shift register, so 16 of 19 fit.
        total++;
        if (fifo_level !== 5'd16 || lost_count !== 16'd3 || overflow !== 1'b1) begin
            bad++;
            $display("FAIL ovf_state got l=%0d lost=%0d o=%b want 16/3/1",
                     fifo_level, lost_count, overflow);
        end
        out_ack = 1'b1;
        n = 0;
        for (int c = 0; c < 300; c++) begin
            if (out_valid) n++;
            else if (n > 0) break;
            @(negedge clk);
        end
        total++;
        if (n != 102 || fifo_level !== '0) begin
            bad++;
            $display("FAIL ovf_drain got bytes=%0d l=%0d want 102/0",
                     n, fifo_level);
        end
        for (int r = 0; r < 2; r++) begin
            rec_data  = '0;
            rec_ready = 1'b1;
            @(negedge clk);
            rec_ready = 1'b0;
            @(negedge clk);
            for (int i = 0; i < 6; i++) begin
                total++;
                if (out_valid !== 1'b1 ||
                    out_byte !== (r == 0 ? expm[i] : 8'h00)) begin
                    bad++;
                    $display("FAIL ovf_marker r%0d b%0d got v=%b b=%h want 1/%h",
                             r, i, out_valid, out_byte,
                             r == 0 ? expm[i] : 8'h00);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        out_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rec_data  = {$urandom, $urandom};
            rec_ready = 1'b1;
            @(negedge clk);
        end
        rec_ready = 1'b0;
        out_ack   = 1'b1;
        n = 0;
        for (int c = 0; c < 40; c++) begin
            if (!out_valid) break;
            n++;
            @(negedge clk);
        end
        total++;
        if (n != 18) begin
            bad++;
            $display("FAIL b2b_run got=%0d want=18", n);
        end
    endtask

    task automatic test_reset_mid();
        out_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rec_data  = {$urandom, $urandom};
            rec_ready = 1'b1;
            @(negedge clk);
        end
        rec_ready = 1'b0;
        out_ack   = 1'b1;
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || fifo_level !== '0 ||
            lost_count !== '0 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_async got v=%b l=%0d lost=%0d o=%b want 0",
                     out_valid, fifo_level, lost_count, overflow);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL rstmid_quiet%0d got v=%b want 0", i, out_valid);
            end
        end
    endtask

    task automatic test_enable();
        enable  = 1'b0;
        out_ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rec_data  = {$urandom, $urandom};
            rec_ready = 1'b1;
            @(negedge clk);
        end
        rec_ready = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (fifo_level !== '0 || lost_count !== '0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL enable_off got l=%0d lost=%0d v=%b want 0/0/0",
                     fifo_level, lost_count, out_valid);
        end
        enable = 1'b1;
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            rec_data = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) rec_data[44:40] = 5'b0;
            rec_ready = ($urandom_range(0, 3) == 0);
            enable    = ($urandom_range(0, 9) != 0);
            out_ack   = ($urandom_range(0, 9) < 7);
            @(negedge clk);
        end
        rec_ready = 1'b0;
        out_ack   = 1'b1;
        for (int c = 0; c < 300; c++) begin
            if (!out_valid && fifo_level == '0) break;
            @(negedge clk);
        end
        total++;
        if (out_valid !== 1'b0 || fifo_level !== '0) begin
            bad++;
            $display("FAIL rand_drain got v=%b l=%0d want 0/0",
                     out_valid, fifo_level);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        test_enable();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
